stopwatch_seg7_scan: RTL
========================

# stopwatch_seg7_scan

Display-side consumer of the stopwatch's four BCD digit counts: minutes tens, minutes ones, seconds tens, seconds ones. It time-multiplexes the digits onto a 4-digit common-anode seven-segment display and lights the decimal point of the minutes-ones digit as the minutes/seconds separator. It also blinks the digit pair under adjustment. It runs on the fast board clock, downstream of the counter block. It samples the counts coherently once per scan frame so the display never tears.

## Interface

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz); must be ≥ 2.
- BLINK_DIV, 25000000: clk cycles per blink phase toggle (2 Hz blink at 100 MHz); must be ≥ 2.

Ports:
- clk  input  1  board clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- min_first_cnt  input  4  minutes tens digit, BCD.
- min_second_cnt  input  4  minutes ones digit, BCD.
- sec_first_cnt  input  4  seconds tens digit, BCD.
- sec_second_cnt  input  4  seconds ones digit, BCD.
- adj  input  1  1 = adjust mode; enables blinking.
- sel  input  1  in adjust mode, 0 blinks the minutes pair and 1 blinks the seconds pair.
- an  output  4  digit enables, active low; an[3] is the leftmost digit.
- seg  output  8  segment drives, active low; {dp,g,f,e,d,c,b,a}.

## Operation

Refresh counter:
- ref_cnt counts 0..REFRESH_DIV-1 and wraps.
- tick = (ref_cnt == REFRESH_DIV-1).

Digit index:
- idx is 2 bits, 0→1→2→3→0, advancing on tick.
- Slot mapping: idx 0 → min_first, an=1110 reversed, i.e. an=4'b0111; idx 1 → min_second, an=4'b1011; idx 2 → sec_first, an=4'b1101; idx 3 → sec_second, an=4'b1110.

Shadow register:
- Holds the four input digits.
- Loads all four together only on the cycle where tick && idx==3, i.e. at the frame boundary.
- Input changes at any other time have no effect until the next boundary.

Blink generator:
- blink_cnt counts 0..BLINK_DIV-1 and wraps.
- blink_on toggles when blink_cnt == BLINK_DIV-1.
- blink_cnt and blink_on run continuously, independent of adj.

Blanking:
- Blanking applies when adj=1 and blink_on=1 and the slot belongs to the selected pair: sel=0 → idx 0,1; sel=1 → idx 2,3.
- A blanked slot drives an=4'b1111 and seg=8'hFF.
- When adj=0, no slot is ever blanked.
- adj and sel are sampled combinationally into the output register each cycle and are not shadowed.

Decode, seg[6:0] active low:
- 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10 (hex).
- 10–15 → 3F (dash: segment g only).

Decimal point:
- seg[7] = 0 (lit) only when idx==1 and the slot is not blanked; otherwise 1.

## Timing

Reset values:
- Asynchronous on rst: ref_cnt=0, idx=0, blink_cnt=0, blink_on=0, shadow digits all 0.
- Outputs during reset: an=4'b1111, seg=8'hFF.

Output register:
- an and seg are registered and reloaded every cycle from the current idx, shadow, adj, sel and blink_on.
- Latency is one cycle after any of these inputs changes.
- First edge after rst deasserts: an=4'b0111, seg=8'hC0 (a zero on the leftmost digit).

Slot and frame:
- Each slot lasts exactly REFRESH_DIV cycles; a frame lasts 4·REFRESH_DIV cycles.
- The idx change and the shadow load happen on the same edge.
- The first frame after reset displays the shadow reset value (0000).
- New digits appear on outputs one cycle after the boundary edge.

Simultaneous and boundary events:
- tick at the same time as a blink toggle: both take effect on that edge with no priority interaction.
- Counter wrap-around is modulo with no extra dead cycle.
- rst asserted mid-slot clears everything immediately, regardless of clk; the scan restarts at idx 0.

Glitch rule:
- an and seg never show a combination from two different idx values on the same cycle, because both come from the same register stage.

## Test plan

Use REFRESH_DIV=4 and BLINK_DIV=8 unless stated.

1. Reset: hold rst across a clk edge → an=1111, seg=FF. After release, the first edge gives an=0111, seg=C0. Digits held at 1,2,3,4 during the first frame still display 0000.
2. Scan: inputs 1,2,3,4; after the first boundary, successive 4-cycle slots show (0111,F9), (1011,24), (1101,B0), (1110,99), repeating with period 16.
3. Coherence: change the inputs to 9,8,7,6 mid-frame (during idx 1) → the current frame still shows 1,2,3,4. The next frame shows (0111,90), (1011,00), (1101,F8), (1110,82).
4. Invalid BCD: min_first_cnt=4'hC after a boundary → slot 0 shows seg=BF, and the other digits decode normally.
5. Blink: adj=1, sel=1 → idx 2,3 slots give an=1111 and seg=FF while blink_on=1, normal display while blink_on=0, with a toggle every 8 cycles. sel=0 → idx 0,1 are blanked instead, and the dp is also dark. adj=0 → never blanked.
6. Mid-operation reset: assert rst asynchronously between edges during idx 2 → outputs go to 1111/FF immediately. After release, the scan restarts at idx 0 with shadow 0000 and blink_on=0.

Source files
------------

// File: rtl/stopwatch_seg7_scan_if.sv
// stopwatch_seg7_scan_if
//   Connects the stopwatch counter block to the seven-segment scanner.
//   Signals:
//     min_first_cnt, min_second_cnt, sec_first_cnt, sec_second_cnt : BCD digits
//     adj : adjust mode (enables blinking)
//     sel : 0 blinks the minutes pair, 1 blinks the seconds pair
//     an  : digit enables, active low, an[3] = leftmost
//     seg : segments, active low, {dp,g,f,e,d,c,b,a}
//   Modports: master = digit source / display sink, slave = scanner.
interface stopwatch_seg7_scan_if;
  logic [3:0] min_first_cnt;
  logic [3:0] min_second_cnt;
  logic [3:0] sec_first_cnt;
  logic [3:0] sec_second_cnt;
  logic       adj;
  logic       sel;
  logic [3:0] an;
  logic [7:0] seg;

  modport master (
    output min_first_cnt, min_second_cnt, sec_first_cnt, sec_second_cnt,
    output adj, sel,
    input  an, seg
  );

  modport slave (
    input  min_first_cnt, min_second_cnt, sec_first_cnt, sec_second_cnt,
    input  adj, sel,
    output an, seg
  );
endinterface

// File: rtl/stopwatch_seg7_scan.sv
// stopwatch_seg7_scan
//   Time-multiplexes four BCD stopwatch digits onto a 4-digit common-anode
//   seven-segment display. Digits are shadowed once per scan frame so a
//   frame never mixes old and new counts. The minutes-ones dp is the MM.SS
//   separator; in adjust mode the selected digit pair blinks.
//   Ports:
//     clk : board clock, rising edge
//     rst : asynchronous, active-high reset
//     bus : stopwatch_seg7_scan_if.slave (digits, adj/sel in; an/seg out)
module stopwatch_seg7_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                        clk,
  input  logic                        rst,
  stopwatch_seg7_scan_if.slave        bus
);

  localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV   > 2) ? $clog2(BLINK_DIV)   : 1;

  logic [REF_W-1:0]  r_ref_cnt;
  logic [BLK_W-1:0]  r_blink_cnt;
  logic              r_blink_on;
  logic [1:0]        r_idx;
  // slot order: [0]=min tens, [1]=min ones, [2]=sec tens, [3]=sec ones
  logic [3:0][3:0]   r_shadow;
  logic [3:0]        r_an;
  logic [7:0]        r_seg;

  logic              w_tick;
  logic              w_blink_wrap;
  logic              w_blank;
  logic [3:0]        w_digit;
  logic [3:0]        w_an_nxt;
  logic [7:0]        w_seg_nxt;

  function automatic logic [6:0] f_decode(input logic [3:0] d);
    case (d)
      4'd0:    f_decode = 7'h40;
      4'd1:    f_decode = 7'h79;
      4'd2:    f_decode = 7'h24;
      4'd3:    f_decode = 7'h30;
      4'd4:    f_decode = 7'h19;
      4'd5:    f_decode = 7'h12;
      4'd6:    f_decode = 7'h02;
      4'd7:    f_decode = 7'h78;
      4'd8:    f_decode = 7'h00;
      4'd9:    f_decode = 7'h10;
      default: f_decode = 7'h3F; // non-BCD shows a dash
    endcase
  endfunction

  assign w_tick       = (r_ref_cnt   == REF_W'(REFRESH_DIV - 1));
  assign w_blink_wrap = (r_blink_cnt == BLK_W'(BLINK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ref_cnt   <= '0;
      r_idx       <= '0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b0;
      r_shadow    <= '0;
    end else begin
      r_ref_cnt   <= w_tick ? '0 : r_ref_cnt + 1'b1;
      r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
      if (w_blink_wrap) r_blink_on <= ~r_blink_on;
      if (w_tick) r_idx <= r_idx + 2'd1;
      // frame boundary: capture all four digits together
      if (w_tick && r_idx == 2'd3)
        r_shadow <= {bus.sec_second_cnt, bus.sec_first_cnt,
                     bus.min_second_cnt, bus.min_first_cnt};
    end
  end

  always_comb begin
    w_digit   = r_shadow[r_idx];
    w_blank   = bus.adj && r_blink_on && (bus.sel ? r_idx[1] : !r_idx[1]);
    w_an_nxt  = ~(4'b1000 >> r_idx);
    w_seg_nxt = {(r_idx != 2'd1), f_decode(w_digit)};
    if (w_blank) begin
      w_an_nxt  = 4'hF;
      w_seg_nxt = 8'hFF;
    end
  end

  // an and seg share one register stage so they always agree on idx
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= 4'hF;
      r_seg <= 8'hFF;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign bus.an  = r_an;
  assign bus.seg = r_seg;

endmodule
